wb_writer: RTL and testbench
============================

Name: wb_writer

Overview:
- Writeback-side writer for the 32x32 CPU register file.
- Accepts results from the single-cycle ALU path and the load/memory path via valid/ready.
- Buffers results in a small in-order FIFO and issues at most one registered write per cycle to the register file write port.
- Provides combinational pending-write (busy) lookups for two decode source operands so the decode stage can stall on RAW hazards.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_valid  in  1  load result valid.
- mem_ready  out  1  load result accepted when mem_valid && mem_ready.
- mem_rd  in  AW  load destination register.
- mem_data  in  DW  load result.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- rf_wen  out  1  register file write enable (registered).
- rf_wa  out  AW  register file write address (registered).
- rf_wd  out  DW  register file write data (registered).
- q_rs  in  AW  decode source operand 1 query.
- q_rt  in  AW  decode source operand 2 query.
- busy_rs  out  1  write pending for q_rs.
- busy_rt  out  1  write pending for q_rt.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous, active-low.
- Reset, sampled at a clk edge with rst_n=0:
  - count, read pointer and write pointer cleared to 0.
  - rf_wen=0, rf_wa=0, rf_wd=0.
  - All FIFO entries invalidated.
  - Reset mid-operation silently drops buffered and in-flight results; no rf_wen pulse follows reset.
- free = DEPTH - count, using the registered count at the start of the cycle. A pop in the same cycle gives no credit.
- Ready generation (combinational; valid must not depend on ready):
  - mem_ready = (free >= 1) || (mem_rd == 0).
  - mem_push = mem_valid && mem_rd != 0 && free >= 1.
  - alu_ready = (alu_rd == 0) || (free >= 2) || (free == 1 && !mem_push).
- rd == 0: the handshake completes but the result is discarded. Nothing is pushed and no rf_wen is produced; register 0 is never written.
- Priority and ordering:
  - mem has priority for the last free slot.
  - When both sources push in one cycle, the mem entry is enqueued first, then the alu entry. Count increases by 2.
- Pop: in any cycle with count > 0, the head entry is popped. At that edge rf_wen=1, rf_wa=head.rd, rf_wd=head.data. Otherwise rf_wen=0 at the edge, and rf_wa/rf_wd hold their values.
- Latency:
  - Handshake in cycle N → entry stored at the end of N → popped in N+1 → rf_wen high in cycle N+2 (FIFO empty case).
  - Register file commits at the end of N+2.
  - Throughput: 1 write per cycle.
- Simultaneous push and pop: count_next = count + pushes - pop. Push into the slot freed by this cycle's pop is not permitted because free excludes the pop.
- Pointers wrap modulo DEPTH. full and empty derive from count, not from pointer compare.
- Busy lookup (combinational):
  - busy_rs = (q_rs != 0) && (any valid FIFO entry with rd == q_rs, or rf_wen && rf_wa == q_rs).
  - busy_rt is identical, using q_rt.
  - Results in their handshake cycle are not included.
- Same-rd writes are committed in acceptance order, so the last write wins.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle (cycle 0) → rf_wen=1, rf_wa=5, rf_wd=0x1234 in cycle 2 only; busy_rs=1 for q_rs=5 in cycles 1–2, 0 in cycle 3.
- From empty: mem (rd=3, 0xAAAA) and alu (rd=4, 0xBBBB) valid in the same cycle → both ready; writes to r3 then r4 in consecutive cycles.
- Hold mem_valid (rd=7) every cycle with alu_valid (rd=8) and DEPTH=4 → count ≤ 4 always; when free==1, mem_ready=1 and alu_ready=0; full asserts; no lost or duplicated writes (scoreboard check).
- alu_rd=0, data 0xFFFF, with FIFO full → alu_ready=1, no push, no rf_wen to address 0; busy_rs=0 for q_rs=0.
- Three ALU writes to r9 (1, 2, 3) back-to-back → rf_wd sequence 1, 2, 3 on r9; busy for r9 deasserts only after the third write's cycle.
- Fill FIFO with 3 entries, assert rst_n=0 for one edge → next cycle count=0, empty=1, rf_wen=0; no stale writes afterwards.

Source files
------------

// File: rtl/wb_writer.sv
// ---------------------------------------------------------------------------
// wb_writer
//
// Writeback-side writer for the 32x32 CPU register file. Results from the
// load/memory path and the single-cycle ALU path are accepted via
// valid/ready, buffered in a small in-order FIFO, and drained at one
// registered register-file write per cycle. Combinational busy lookups let
// decode stall on RAW hazards against writes that are still pending.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   mem_valid/mem_ready/mem_rd/mem_data   load result handshake
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   rf_wen/rf_wa/rf_wd              registered register-file write port
//   q_rs/q_rt -> busy_rs/busy_rt    pending-write lookups for decode
//   full/empty                      FIFO occupancy flags (from count)
// ---------------------------------------------------------------------------
module wb_writer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,

    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,

    output logic          rf_wen,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,

    input  logic [AW-1:0] q_rs,
    input  logic [AW-1:0] q_rt,
    output logic          busy_rs,
    output logic          busy_rt,

    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // FIFO storage: payload plus a per-entry valid bit used by busy lookup.
    logic [AW-1:0]    ent_rd   [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [CW-1:0] count_next;

    logic          mem_nz;
    logic          alu_nz;
    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic [PW-1:0] alu_slot;

    // -----------------------------------------------------------------------
    // Handshake / push decisions. free uses the registered count only, so a
    // pop in this cycle never frees space for a push in the same cycle.
    // -----------------------------------------------------------------------
    assign free   = DEPTH_C - count;
    assign mem_nz = (mem_rd != '0);
    assign alu_nz = (alu_rd != '0);

    // rd == 0 results are accepted unconditionally and dropped.
    assign mem_ready = (free != '0) || !mem_nz;
    assign mem_push  = mem_valid && mem_nz && (free != '0);

    // mem owns the last free slot; alu only gets it when mem is not pushing.
    assign alu_ready = !alu_nz || (free >= CW'(2)) || ((free == CW'(1)) && !mem_push);
    assign alu_push  = alu_valid && alu_nz && alu_ready;

    assign pop = (count != '0);

    // When both push, mem goes first so the alu entry lands one slot later.
    assign alu_slot = wr_ptr + PW'(mem_push);

    assign count_next = count + CW'(mem_push) + CW'(alu_push) - CW'(pop);

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // -----------------------------------------------------------------------
    // Control state and the registered write port.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation results that synthesis does not reproduce.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            ent_valid <= '0;
            rf_wen    <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
        end else begin
            count  <= count_next;
            wr_ptr <= wr_ptr + PW'(mem_push) + PW'(alu_push);
            rf_wen <= pop;

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                rf_wa  <= ent_rd[rd_ptr];
                rf_wd  <= ent_data[rd_ptr];
            end

            // The popped slot is occupied and pushed slots are free at the
            // start of the cycle, so these indices never collide.
            if (pop)      ent_valid[rd_ptr]   <= 1'b0;
            if (mem_push) ent_valid[wr_ptr]   <= 1'b1;
            if (alu_push) ent_valid[alu_slot] <= 1'b1;
        end
    end

    // NOTE: the payload array is deliberately not reset; ent_valid and count
    // already mark every slot empty, so clearing the data would only add
    // reset fan-out to a memory that is never read while invalid.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            ent_rd[wr_ptr]   <= mem_rd;
            ent_data[wr_ptr] <= mem_data;
        end
        if (alu_push) begin
            ent_rd[alu_slot]   <= alu_rd;
            ent_data[alu_slot] <= alu_data;
        end
    end

    // -----------------------------------------------------------------------
    // Busy lookup: a query hits any buffered entry or the write currently on
    // the register-file port. Results still in their handshake cycle are not
    // visible yet; decode sees them one cycle later.
    // -----------------------------------------------------------------------
    logic hit_rs;
    logic hit_rt;

    // NOTE: both flags get a default before the loop so no path through this
    // block leaves them unassigned, which would infer a latch.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == q_rs)) hit_rs = 1'b1;
            if (ent_valid[i] && (ent_rd[i] == q_rt)) hit_rt = 1'b1;
        end
    end

    assign busy_rs = (q_rs != '0) && (hit_rs || (rf_wen && (rf_wa == q_rs)));
    assign busy_rt = (q_rt != '0) && (hit_rt || (rf_wen && (rf_wa == q_rt)));

endmodule

// File: tb/tb_wb_writer.sv
// ---------------------------------------------------------------------------
// tb_wb_writer
//
// Self-checking bench for wb_writer. A queue-based reference model holds the
// results that have been accepted but not yet written; every cycle the bench
// derives ready, flags, busy and the expected register-file write from that
// queue and compares them with the design.
// ---------------------------------------------------------------------------
module tb_wb_writer;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk;
    logic          rst_n;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          rf_wen;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [AW-1:0] q_rs;
    logic [AW-1:0] q_rt;
    logic          busy_rs;
    logic          busy_rt;
    logic          full;
    logic          empty;

    wb_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .rf_wen    (rf_wen),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .q_rs      (q_rs),
        .q_rt      (q_rt),
        .busy_rs   (busy_rs),
        .busy_rt   (busy_rt),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending results in acceptance order, plus the write
    // expected on the register-file port in the current cycle.
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mq[$];
    logic          exp_wen;
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;

    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A register is pending if any accepted, not yet committed result or the
    // write on the port targets it. Register 0 is never pending.
    function automatic bit model_busy(input logic [AW-1:0] q);
        bit hit;
        hit = exp_wen && (exp_wa == q);
        foreach (mq[i]) if (mq[i].rd == q) hit = 1'b1;
        return (q != '0) && hit;
    endfunction

    task automatic drive(input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                         input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic [AW-1:0] qs, input logic [AW-1:0] qt);
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = md;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        q_rs      = qs;
        q_rt      = qt;
    endtask

    task automatic idle(input logic [AW-1:0] qs, input logic [AW-1:0] qt);
        drive(1'b0, '0, '0, 1'b0, '0, '0, qs, qt);
    endtask

    // One clock cycle: inputs are already applied (after a falling edge).
    // Check everything visible now, then advance the model across the edge.
    task automatic tick();
        int     free;
        int     left;
        bit     exp_mr;
        bit     exp_ar;
        bit     macc;
        bit     aacc;
        entry_t e;
        #1;
        free   = DEPTH - mq.size();
        exp_mr = (mem_rd == '0) || (free > 0);
        macc   = mem_valid && (mem_rd != '0) && (free > 0);
        // Whatever room mem leaves behind is available to alu.
        left   = free - (macc ? 1 : 0);
        exp_ar = (alu_rd == '0) || (left > 0);
        aacc   = alu_valid && (alu_rd != '0) && exp_ar;

        check("mem_ready", mem_ready, exp_mr);
        check("alu_ready", alu_ready, exp_ar);
        check("full",      full,      mq.size() == DEPTH);
        check("empty",     empty,     mq.size() == 0);
        check("rf_wen",    rf_wen,    exp_wen);
        check("rf_wa",     rf_wa,     exp_wa);
        check("rf_wd",     rf_wd,     exp_wd);
        check("busy_rs",   busy_rs,   model_busy(q_rs));
        check("busy_rt",   busy_rt,   model_busy(q_rt));

        if (mq.size() > 0) begin
            e       = mq.pop_front();
            exp_wen = 1'b1;
            exp_wa  = e.rd;
            exp_wd  = e.data;
        end else begin
            exp_wen = 1'b0;
        end
        if (macc) begin
            e.rd = mem_rd; e.data = mem_data; mq.push_back(e);
        end
        if (aacc) begin
            e.rd = alu_rd; e.data = alu_data; mq.push_back(e);
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle('0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        mq.delete();
        exp_wen = 1'b0;
        exp_wa  = '0;
        exp_wd  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        exp_wen = 1'b0;
        exp_wa  = '0;
        exp_wd  = '0;
        idle('0, '0);
        @(negedge clk);
        do_reset();

        // Reset state.
        tick();

        // Single ALU write to r5; watch busy for r5 across the latency.
        drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle(5'd5, 5'd0);
            tick();
        end

        // mem and alu together from empty: r3 then r4.
        drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 5'd3, 5'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            idle(5'd3, 5'd4);
            tick();
        end

        // Sustained pressure from both sources; alu loses the last slot.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'd7, 32'h7000 + i, 1'b1, 5'd8, 32'h8000 + i, 5'd7, 5'd8);
            tick();
        end

        // alu_rd == 0 under pressure: accepted but discarded.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd7, 32'h7100 + i, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd7);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            idle(5'd7, 5'd0);
            tick();
        end

        // Three back-to-back writes to r9: last one wins.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, '0, '0, 1'b1, 5'd9, i, 5'd9, 5'd9);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            idle(5'd9, 5'd9);
            tick();
        end

        // Build up three entries, then reset mid-operation.
        drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 5'd10, 5'd11);
        tick();
        drive(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD0, 5'd12, 5'd13);
        tick();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(5'd12, 5'd13);
            tick();
        end

        // Randomised traffic with hazards on a small register window.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            idle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
